// File: rtl/util_adc_diff_mc.sv
// Multi-channel ADC crossing detector: per channel, the sample delta (or raw level)
// is compared against signed thresholds and a POS/NEG/IDLE state is held until timeout.
module util_adc_diff_mc #(
  parameter int CHANNELS     = 2,
  parameter int WORD_WIDTH   = 1,
  parameter int BYTE_WIDTH   = 1,
  parameter int UP_THRESH    = 64,
  parameter int LOW_THRESH   = -64,
  parameter int NO_DIFF_WAIT = 50,
  parameter int DIFF_MODE    = 0
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic [CHANNELS*WORD_WIDTH*BYTE_WIDTH*8-1:0]   rd_data,
  input  logic                                          rd_valid,
  input  logic                                          rd_enable,
  output logic [CHANNELS*2-1:0]                         diff_out,
  output logic                                          diff_valid
);

  localparam int W  = WORD_WIDTH * BYTE_WIDTH * 8;
  localparam int CW = (NO_DIFF_WAIT > 0) ? $clog2(NO_DIFF_WAIT + 1) : 1;

  // Thresholds live in the same W+1 bit domain as the metric so a full-scale delta never wraps.
  localparam logic signed [W:0]  UP_M   = signed'((W + 1)'(UP_THRESH));
  localparam logic signed [W:0]  LOW_M  = signed'((W + 1)'(LOW_THRESH));
  localparam logic [CW-1:0]      WAIT_C = CW'(NO_DIFF_WAIT);

  // Handshake: a sample is taken on any rising edge with rd_valid=1 and rd_enable=1;
  // there is no backpressure, and diff_valid pulses for exactly one cycle per taken sample.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_NEG  = 2'b01,
    ST_POS  = 2'b10
  } state_t;

  state_t          state_q  [CHANNELS];
  state_t          state_d  [CHANNELS];
  logic [W-1:0]    prev_q   [CHANNELS];
  logic [W-1:0]    prev_d   [CHANNELS];
  logic [CW-1:0]   cnt_q    [CHANNELS];
  logic [CW-1:0]   cnt_d    [CHANNELS];
  logic [CHANNELS-1:0] primed_q;
  logic [CHANNELS-1:0] primed_d;
  logic            diff_valid_q;
  logic            diff_valid_d;

  always_comb begin
    logic [W-1:0]     sample;
    logic signed [W:0] metric;
    logic [CW-1:0]    cnt_inc;
    diff_valid_d = rd_valid & rd_enable;
    primed_d     = primed_q;
    for (int k = 0; k < CHANNELS; k++) begin
      state_d[k] = state_q[k];
      prev_d[k]  = prev_q[k];
      cnt_d[k]   = cnt_q[k];
      sample     = rd_data[k*W +: W];
      metric     = '0;
      cnt_inc    = (cnt_q[k] == '1) ? cnt_q[k] : cnt_q[k] + 1'b1;
      if (!rd_enable) begin
        state_d[k]  = ST_IDLE;
        primed_d[k] = 1'b0;
        cnt_d[k]    = '0;
      end else if (rd_valid) begin
        prev_d[k]   = sample;
        primed_d[k] = 1'b1;
        if (DIFF_MODE != 0 || primed_q[k]) begin
          if (DIFF_MODE != 0) metric = $signed({sample[W-1], sample});
          else metric = $signed({sample[W-1], sample}) - $signed({prev_q[k][W-1], prev_q[k]});
          if (metric >= UP_M) begin
            state_d[k] = ST_POS;
            cnt_d[k]   = '0;
          end else if (metric <= LOW_M) begin
            state_d[k] = ST_NEG;
            cnt_d[k]   = '0;
          end else if (state_q[k] != ST_IDLE) begin
            if (NO_DIFF_WAIT != 0 && cnt_inc == WAIT_C) begin
              state_d[k] = ST_IDLE;
              cnt_d[k]   = '0;
            end else begin
              cnt_d[k]   = cnt_inc;
            end
          end else begin
            cnt_d[k] = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= ST_IDLE;
        prev_q[k]  <= '0;
        cnt_q[k]   <= '0;
      end
      primed_q     <= '0;
      diff_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= state_d[k];
        prev_q[k]  <= prev_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      primed_q     <= primed_d;
      diff_valid_q <= diff_valid_d;
    end
  end

  // The per-channel state registers are the output; no extra output stage.
  always_comb begin
    diff_out = '0;
    for (int k = 0; k < CHANNELS; k++) diff_out[k*2 +: 2] = state_q[k];
  end

  assign diff_valid = diff_valid_q;

endmodule

// File: tb/tb_util_adc_diff_mc.sv
// Bench for util_adc_diff_mc: directed vectors into a delta-mode and a level-mode
// instance, expected states queued on issue and popped by a monitor on diff_valid.
module tb_util_adc_diff_mc;

  logic        clk;
  logic        rstn;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_enable;
  logic [3:0]  diff_out;
  logic        diff_valid;
  logic [15:0] l_data;
  logic        l_valid;
  logic        l_enable;
  logic [3:0]  l_out;
  logic        l_dv;

  logic [3:0] exp_q[$];
  logic [3:0] lvl_q[$];
  int n_checks = 0;
  int n_errors = 0;

  int m_prev[2];
  int m_st[2];
  int m_cnt[2];
  bit m_primed[2];

  util_adc_diff_mc #(.CHANNELS(2), .WORD_WIDTH(1), .BYTE_WIDTH(1), .UP_THRESH(64),
    .LOW_THRESH(-64), .NO_DIFF_WAIT(50), .DIFF_MODE(0)) dut (
    .clk(clk), .rstn(rstn), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_enable(rd_enable), .diff_out(diff_out), .diff_valid(diff_valid));

  util_adc_diff_mc #(.CHANNELS(2), .WORD_WIDTH(1), .BYTE_WIDTH(1), .UP_THRESH(64),
    .LOW_THRESH(-64), .NO_DIFF_WAIT(50), .DIFF_MODE(1)) dut_lvl (
    .clk(clk), .rstn(rstn), .rd_data(l_data), .rd_valid(l_valid),
    .rd_enable(l_enable), .diff_out(l_out), .diff_valid(l_dv));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    if (rstn) begin
      if (diff_out[1:0] == 2'b11 || diff_out[3:2] == 2'b11) begin
        n_checks++;
        n_errors++;
        $display("FAIL illegal_state: diff_out %b at %0t", diff_out, $time);
      end
      if (diff_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_valid: diff_out %b with no sample pending at %0t", diff_out, $time);
        end else begin
          chk("dout", diff_out, exp_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && l_dv) begin
      if (lvl_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_lvl_valid: l_out %b at %0t", l_out, $time);
      end else begin
        chk("lvl_out", l_out, lvl_q.pop_front());
      end
    end
  end

  // drivers
  task automatic send(input logic [7:0] c0, input logic [7:0] c1, input logic [3:0] e);
    rd_data   = {c1, c0};
    rd_valid  = 1'b1;
    rd_enable = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic lsend(input logic [7:0] c0, input logic [7:0] c1, input logic [3:0] e);
    l_data  = {c1, c0};
    l_valid = 1'b1;
    lvl_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic pause(input int n);
    rd_valid = 1'b0;
    l_valid  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // A sample offered with enable low must be ignored and the outputs cleared.
  task automatic disable_cycle();
    rd_enable = 1'b0;
    rd_valid  = 1'b1;
    rd_data   = 16'hA5A5;
    @(posedge clk); #1;
    chk("disable_out", diff_out, 4'b0000);
    chk("disable_valid", {3'b000, diff_valid}, 4'b0000);
    rd_enable = 1'b1;
    rd_valid  = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_cnt[k] = 0; m_primed[k] = 1'b0;
    end
  endtask

  task automatic model_accept(input logic [15:0] d, output logic [3:0] e);
    int x;
    int metric;
    for (int k = 0; k < 2; k++) begin
      x = $signed(d[k*8 +: 8]);
      if (!m_primed[k]) begin
        m_primed[k] = 1'b1;
      end else begin
        metric = x - m_prev[k];
        if (metric >= 64) begin m_st[k] = 2; m_cnt[k] = 0; end
        else if (metric <= -64) begin m_st[k] = 1; m_cnt[k] = 0; end
        else if (m_st[k] != 0) begin
          m_cnt[k]++;
          if (m_cnt[k] == 50) begin m_st[k] = 0; m_cnt[k] = 0; end
        end
      end
      m_prev[k] = x;
      e[k*2 +: 2] = 2'(m_st[k]);
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [3:0]  e;
    logic [7:0]  drv[2];
    bit          v;
    bit          en;
    rstn = 1'b0; rd_data = '0; rd_valid = 1'b0; rd_enable = 1'b1;
    l_data = '0; l_valid = 1'b0; l_enable = 1'b1;
    drv[0] = 8'd0; drv[1] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", diff_out, 4'b0000);
    chk("reset_valid", {3'b000, diff_valid}, 4'b0000);
    chk("reset_lvl_out", l_out, 4'b0000);
    rstn = 1'b1;
    @(posedge clk); #1;

    // crossing then hold, timeout on the 50th in-band sample
    send(8'd0, 8'd0, 4'b0000);
    send(8'd100, 8'd0, 4'b0010);
    repeat (49) send(8'd100, 8'd0, 4'b0010);
    send(8'd100, 8'd0, 4'b0000);

    // slow ramp never crosses
    disable_cycle();
    for (int i = 0; i < 240; i++) send(8'(i - 120), 8'd0, 4'b0000);

    // full-scale deltas on ch1 do not wrap
    disable_cycle();
    send(8'd0, 8'h7F, 4'b0000);
    send(8'd0, 8'h80, 4'b0100);
    send(8'd0, 8'h7F, 4'b1000);

    // threshold boundaries
    disable_cycle();
    send(8'd0, 8'd0, 4'b0000);
    send(8'd64, 8'd0, 4'b0010);
    send(8'd127, 8'd0, 4'b0010);
    send(8'd63, 8'd0, 4'b0001);
    send(8'd0, 8'd0, 4'b0001);

    // enable drop in POS, re-prime ignores a 200 jump
    send(8'd100, 8'd0, 4'b0010);
    disable_cycle();
    send(8'h9C, 8'd0, 4'b0000);
    send(8'h9C, 8'd0, 4'b0000);
    send(8'h00, 8'd0, 4'b0010);

    // asynchronous reset between edges
    rd_valid = 1'b0;
    chk("pos_before_rst", diff_out, 4'b0010);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_out", diff_out, 4'b0000);
    chk("async_rst_valid", {3'b000, diff_valid}, 4'b0000);
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    send(8'd120, 8'd0, 4'b0000);
    send(8'd120, 8'd0, 4'b0000);
    pause(3);

    // level mode
    lsend(8'd63, 8'd0, 4'b0000);
    lsend(8'd64, 8'd0, 4'b0010);
    repeat (49) lsend(8'd0, 8'd0, 4'b0010);
    lsend(8'd0, 8'd0, 4'b0000);
    lsend(8'd0, 8'hC0, 4'b0100);
    pause(3);

    // random valid/enable against the reference model
    disable_cycle();
    model_reset();
    for (int n = 0; n < 20000; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 60) != 0);
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 63) == 0) drv[k] = 8'($urandom_range(0, 255));
        else drv[k] = drv[k] + 8'($urandom_range(0, 10)) - 8'd5;
      end
      d = {drv[1], drv[0]};
      rd_data = d; rd_valid = v; rd_enable = en;
      if (!en) model_reset();
      else if (v) begin
        model_accept(d, e);
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    rd_enable = 1'b1;
    pause(5);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL missing_valid: %0d samples pending expected 0", exp_q.size());
    end
    n_checks++;
    if (lvl_q.size() != 0) begin
      n_errors++;
      $display("FAIL missing_lvl_valid: %0d samples pending expected 0", lvl_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
